pc: RTL and testbench

PC -- requirements
Module: pc

---
 rtl/pc_pkg.sv | 7 +
 rtl/pc.sv | 28 ++
 tb/tb_pc.sv | 118 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared defaults for the program counter: address width and reset vector.
package pc_pkg;

  localparam int unsigned PC_XLEN_DEFAULT = 32;
  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc.sv
// Program counter: one XLEN-bit register that loads the externally computed
// next address every cycle and returns to RESET_VECTOR asynchronously.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = PC_XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_out
);

  logic [XLEN-1:0] pc_q;

  // PC register: verbatim load of pc_next, no enable, no alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc_out = pc_q;

endmodule : pc

// File: tb/tb_pc.sv
// Scoreboard bench for pc: driver pushes the expected post-edge PC, a monitor
// pops and compares one cycle later; async reset is checked directly.
module tb_pc;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV = 32'h0000_0000;

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_out;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model_pc;
  logic [XLEN-1:0] mon_exp;

  pc dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc_next(pc_next),
    .pc_out (pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: glitch pc_next, confirm pc_out has not moved,
  // settle on v, and record what the PC must hold after the coming edge.
  task automatic drive(input logic [XLEN-1:0] v, input bit run);
    @(negedge clk);
    rst_n   = run ? 1'b1 : 1'b0;
    pc_next = $urandom;
    #1;
    check("pre_edge_stable", pc_out, model_pc);
    pc_next = v;
    #1;
    model_pc = run ? v : RV;
    exp_q.push_back(model_pc);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", pc_out, RV);
    model_pc = RV;
  endtask

  // Monitor: compare the DUT against the scoreboard just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("post_edge", pc_out, mon_exp);
    end
  end

  initial begin
    rst_n    = 1'b0;
    pc_next  = 32'h0000_0000;
    model_pc = RV;
    #1;
    check("reset_immediate", pc_out, RV);

    // Reset held with clocks running, then release with pc_next = 0
    repeat (3) drive(32'h0000_0000, 1'b0);
    drive(32'h0000_0000, 1'b1);

    // Sequential fetch and jump
    drive(32'h0000_0004, 1'b1);
    drive(32'h0000_0008, 1'b1);
    drive(32'h0000_0064, 1'b1);

    // Async reset mid-run while pc_out = 100, then edges under reset ignored
    async_reset();
    drive(32'h1234_5678, 1'b0);
    drive(32'hDEAD_BEEC, 1'b0);
    drive(32'h0000_0000, 1'b1);

    // Wrap-around
    drive(32'hFFFF_FFFC, 1'b1);
    drive(32'h0000_0000, 1'b1);

    // Hold
    repeat (5) drive(32'h0000_0040, 1'b1);

    // Random jumps, odd addresses and occasional resets
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        async_reset();
        drive($urandom, 1'b0);
      end else begin
        drive($urandom, 1'b1);
      end
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", XLEN'(exp_q.size()), 32'h0000_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc
